video_capture_writer: RTL and testbench
=======================================

Name: video_capture_writer

Overview:
- Write-side counterpart of the display read path: takes a DE-framed parallel RGB stream and writes a cropped source_h x source_v window into the frame-buffer write FIFO.
- Sits between a video input (camera/ISP/HDMI RX) and the frame-buffer write FIFO.
- Provides a per-frame load pulse so the frame-buffer controller can reset its write address.
- Runs entirely on the pixel clock.

Parameters:
- source_h, 800, window width in pixels written per line
- source_v, 480, window height in lines written per frame
- crop_x, 0, first input pixel index (per DE line) inside the window
- crop_y, 0, first DE line index (per frame) inside the window
- video_vsync_pol, 1, 1 = vsync active high, 0 = active low

Ports:
- pixel_clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- video_vsync  in  1  input vertical sync, polarity per video_vsync_pol
- video_den  in  1  input data enable
- video_pixel  in  24  input pixel, RGB from high to low
- wr_load  out  1  write-target update pulse, one cycle at each vsync active edge
- wr_clk  out  1  wr_fifo write clock, equal to pixel_clock
- wrfifo_wren  out  1  wr_fifo write enable
- wrfifo_din  out  32  wr_fifo data, {pixel[23:0], 8'h00}
- wrfifo_full  in  1  wr_fifo full
- frame_done  out  1  one-cycle pulse when the last window pixel is written
- overflow  out  1  sticky flag: a write was dropped because the FIFO was full in this frame
- frame_count  out  16  completed-frame counter, wraps at 65535 to 0

Behaviour:
- Reset state, first cycle after reset: all outputs 0; state WAIT_VS; x = 0, y = 0.
- vs_act = video_vsync when video_vsync_pol = 1, else ~video_vsync. vs_edge = vs_act & ~vs_act_d (registered).
- x (14 bit): +1 each cycle with den = 1; cleared on den falling edge.
- y (14 bit): +1 on each den falling edge; cleared on vs_edge.
- in_win = den & (x >= crop_x) & (x < crop_x + source_h) & (y >= crop_y) & (y < crop_y + source_v).
- States:
  - WAIT_VS: ignore data; on vs_edge -> CAPTURE. Discards the partial frame after reset.
  - CAPTURE: want = in_win.
    - want & ~wrfifo_full: write.
    - want & wrfifo_full: no write; set overflow; -> DROP.
    - Last window pixel written: frame_done = 1 and frame_count + 1 on the next cycle, together with the wren; -> DONE.
  - DROP: no writes until vs_edge.
  - DONE: no writes until vs_edge.
  - vs_edge in CAPTURE, DROP or DONE: -> CAPTURE, with x and y restarted.
- Latency: pixel at cycle N appears on wrfifo_din with wrfifo_wren = 1 at cycle N+1. wrfifo_full is sampled at cycle N.
- wr_load: registered pulse, 1 cycle after vs_edge, in every state including WAIT_VS.
- overflow: cleared on vs_edge. If vs_edge and a drop occur in the same cycle, the drop wins (flag reads 1).
- Short frame (vs_edge before the last window pixel): abandon the frame; no frame_done; frame_count unchanged.
- Window outside the input frame: no frame_done, no error.
- wrfifo_din[7:0] is always 0. When wrfifo_wren = 0, wrfifo_din holds its last value.
- Reset asserted mid-frame: outputs 0 on the next cycle; state returns to WAIT_VS.

Test Plan:
- Common setup: source_h = 4, source_v = 2, crop_x = 1, crop_y = 1. Input frames: 8 px/line DE, 4 lines, pixel = {y, x} pattern.
- 1. Reset, then frame 1 without a preceding vsync, then vsync, then frame 2 -> zero writes during frame 1. Frame 2 gives exactly 8 writes: lines 1–2, x = 1..4, each 1 cycle after its input. frame_done on the 8th write; frame_count = 1.
- 2. vsync pulse -> wr_load high exactly 1 cycle, 1 cycle after the vsync rising edge. Repeat with video_vsync_pol = 0 and an active-low pulse -> same result.
- 3. wrfifo_full = 1 during the 3rd window pixel -> 2 writes only; overflow = 1; no frame_done; frame_count unchanged. The next vsync clears overflow, and the following clean frame writes 8.
- 4. vsync after 2 window lines of 1 -> 4 writes, no frame_done. The next full frame writes 8 and gives frame_done.
- 5. Reset held 1 cycle mid-window -> wren = 0 the next cycle; no further writes until after a vsync.
- 6. Run 65537 frames via force or a short-frame bench -> frame_count wraps to 1.

Source files
------------

// File: rtl/video_capture_writer.sv
// video_capture_writer
// Crops a DE-framed 24-bit RGB stream to a fixed source_h x source_v window
// and pushes the window pixels into the frame-buffer write FIFO. Each vsync
// active edge starts a new capture and pulses wr_load so the frame-buffer
// controller can rewind its write address. A full FIFO aborts the rest of
// the frame instead of writing a torn image.
module video_capture_writer #(
    parameter int source_h        = 800,
    parameter int source_v        = 480,
    parameter int crop_x          = 0,
    parameter int crop_y          = 0,
    parameter int video_vsync_pol = 1
) (
    input  logic        pixel_clock,
    input  logic        reset,
    input  logic        video_vsync,
    input  logic        video_den,
    input  logic [23:0] video_pixel,
    output logic        wr_load,
    output logic        wr_clk,
    output logic        wrfifo_wren,
    output logic [31:0] wrfifo_din,
    input  logic        wrfifo_full,
    output logic        frame_done,
    output logic        overflow,
    output logic [15:0] frame_count
);

    // Window bounds as 16-bit constants. Positions are compared as signed
    // offsets from the window origin, so a zero crop needs no special case.
    localparam logic [15:0] X_LO    = 16'(crop_x);
    localparam logic [15:0] Y_LO    = 16'(crop_y);
    localparam logic [15:0] WIN_H   = 16'(source_h);
    localparam logic [15:0] WIN_V   = 16'(source_v);
    localparam logic [15:0] LAST_DX = 16'(source_h - 1);
    localparam logic [15:0] LAST_DY = 16'(source_v - 1);

    typedef enum logic [1:0] {
        WAIT_VS,
        CAPTURE,
        DROP,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        vs_act;
    logic        vs_act_p1;
    logic        vs_edge;
    logic        den_p1;
    logic        den_fall;
    logic [13:0] x;
    logic [13:0] y;
    logic [15:0] dx;
    logic [15:0] dy;
    logic        in_win;
    logic        last_px;
    logic        want;
    logic        do_write;
    logic        do_drop;

    // The FIFO write port lives in the pixel clock domain.
    assign wr_clk   = pixel_clock;

    // Normalise vsync so that 1 always means "sync active".
    assign vs_act   = (video_vsync_pol != 0) ? video_vsync : ~video_vsync;
    assign vs_edge  = vs_act & ~vs_act_p1;
    assign den_fall = den_p1 & ~video_den;

    // Offset of the current pixel from the window origin; bit 15 set means
    // the pixel lies before the origin.
    assign dx       = {2'b00, x} - X_LO;
    assign dy       = {2'b00, y} - Y_LO;
    assign in_win   = video_den & ~dx[15] & (dx < WIN_H) & ~dy[15] & (dy < WIN_V);
    assign last_px  = in_win & (dx == LAST_DX) & (dy == LAST_DY);

    // Only a frame that started with a seen vsync edge is ever written.
    assign want     = (state == CAPTURE) & in_win;
    assign do_write = want & ~wrfifo_full;
    assign do_drop  = want & wrfifo_full;

    // State register.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state <= WAIT_VS;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: every vsync edge (re)starts a capture; a drop or the
    // final window pixel parks the FSM until the next vsync edge.
    always_comb begin
        state_next = state;
        case (state)
            WAIT_VS: begin
                if (vs_edge) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (vs_edge) begin
                    state_next = CAPTURE;
                end else if (do_drop) begin
                    state_next = DROP;
                end else if (do_write && last_px) begin
                    state_next = DONE;
                end
            end
            DROP, DONE: begin
                if (vs_edge) begin
                    state_next = CAPTURE;
                end
            end
            default: begin
                state_next = WAIT_VS;
            end
        endcase
    end

    // Sync edge detectors and the raster position of the incoming pixel.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            vs_act_p1 <= 1'b0;
            den_p1    <= 1'b0;
            x         <= '0;
            y         <= '0;
        end else begin
            vs_act_p1 <= vs_act;
            den_p1    <= video_den;
            if (vs_edge) begin
                x <= '0;
                y <= '0;
            end else begin
                if (video_den) begin
                    x <= x + 14'd1;
                end else if (den_fall) begin
                    x <= '0;
                end
                if (den_fall) begin
                    y <= y + 14'd1;
                end
            end
        end
    end

    // Output register stage: FIFO write, frame markers and status flags all
    // appear one cycle after the pixel that caused them.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            wr_load     <= 1'b0;
            wrfifo_wren <= 1'b0;
            wrfifo_din  <= '0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            frame_count <= '0;
        end else begin
            wr_load     <= vs_edge;
            wrfifo_wren <= do_write;
            frame_done  <= do_write & last_px;
            if (do_write) begin
                wrfifo_din <= {video_pixel, 8'h00};
            end
            if (do_write && last_px) begin
                frame_count <= frame_count + 16'd1;
            end
            // A drop in the same cycle as a vsync edge must stay visible.
            if (do_drop) begin
                overflow <= 1'b1;
            end else if (vs_edge) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_video_capture_writer.sv
// Testbench for video_capture_writer: 4x2 window at (1,1) over 8-pixel,
// 4-line frames, with a second instance using an active-low vsync.
module tb_video_capture_writer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        vsync;
    logic        vsync_n;
    logic        den;
    logic        full;
    logic [23:0] pixel;

    logic        wr_load, wr_clk, wren, frame_done, overflow;
    logic [31:0] din;
    logic [15:0] frame_count;
    logic        wr_load_n, wr_clk_n, wren_n, frame_done_n, overflow_n;
    logic [31:0] din_n;
    logic [15:0] frame_count_n;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_din;
    int          nwr;
    int          nd;

    typedef struct {
        bit vs_before;
        int nlines;
        int full_idx;
        int exp_writes;
        int exp_done;
        int exp_count;
        bit exp_ovf;
    } vec_t;

    vec_t vecs[6];

    video_capture_writer #(
        .source_h(4), .source_v(2), .crop_x(1), .crop_y(1), .video_vsync_pol(1)
    ) u_dut (
        .pixel_clock(clk), .reset(reset), .video_vsync(vsync), .video_den(den),
        .video_pixel(pixel), .wr_load(wr_load), .wr_clk(wr_clk),
        .wrfifo_wren(wren), .wrfifo_din(din), .wrfifo_full(full),
        .frame_done(frame_done), .overflow(overflow), .frame_count(frame_count)
    );

    video_capture_writer #(
        .source_h(4), .source_v(2), .crop_x(1), .crop_y(1), .video_vsync_pol(0)
    ) u_dut_n (
        .pixel_clock(clk), .reset(reset), .video_vsync(vsync_n), .video_den(den),
        .video_pixel(pixel), .wr_load(wr_load_n), .wr_clk(wr_clk_n),
        .wrfifo_wren(wren_n), .wrfifo_din(din_n), .wrfifo_full(full),
        .frame_done(frame_done_n), .overflow(overflow_n), .frame_count(frame_count_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One DE pixel; both instances must agree with the bench's expectation.
    task automatic px_cycle(input int l, input int p, input bit f, input bit exp_wr, input bit exp_done);
        logic [23:0] px;
        px    = {8'(l), 8'(p), 8'h5A};
        den   = 1'b1;
        pixel = px;
        full  = f;
        cycle();
        if (exp_wr) last_din = {px, 8'h00};
        check("wren", 32'(wren), 32'(exp_wr));
        check("din", din, last_din);
        check("frame_done", 32'(frame_done), 32'(exp_done));
        check("wren_n", 32'(wren_n), 32'(exp_wr));
        check("din_n", din_n, last_din);
        check("frame_done_n", 32'(frame_done_n), 32'(exp_done));
    endtask

    task automatic gap();
        den  = 1'b0;
        full = 1'b0;
        cycle();
        check("gap_wren", 32'(wren), 32'd0);
        check("gap_din_hold", din, last_din);
        cycle();
    endtask

    task automatic vsync_pulse();
        den     = 1'b0;
        full    = 1'b0;
        vsync   = 1'b1;
        vsync_n = 1'b0;
        cycle();
        check("wr_load_rise", 32'(wr_load), 32'd1);
        check("wr_load_n_rise", 32'(wr_load_n), 32'd1);
        check("wr_clk", 32'(wr_clk), 32'(clk));
        check("wr_clk_n", 32'(wr_clk_n), 32'(clk));
        cycle();
        check("wr_load_one_cycle", 32'(wr_load), 32'd0);
        check("wr_load_n_one_cycle", 32'(wr_load_n), 32'd0);
        vsync   = 1'b0;
        vsync_n = 1'b1;
        cycle();
        cycle();
        check("wr_load_idle", 32'(wr_load), 32'd0);
        check("wr_load_n_idle", 32'(wr_load_n), 32'd0);
    endtask

    // Frame of nlines x 8 pixels; window pixels are indexed 0..7 in raster
    // order, and full_idx marks the one that meets a full FIFO.
    task automatic send_frame(input int nlines, input bit alive, input int full_idx,
                              output int n_wr, output int n_done);
        bit dropped;
        dropped = 1'b0;
        n_wr    = 0;
        n_done  = 0;
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < 8; p++) begin
                int idx;
                bit f;
                bit exp_wr;
                idx = ((l >= 1) && (l <= 2) && (p >= 1) && (p <= 4)) ? (l - 1) * 4 + (p - 1) : -1;
                f = (idx >= 0) && (idx == full_idx);
                exp_wr = alive && (idx >= 0) && !dropped && !f;
                if (alive && f) dropped = 1'b1;
                px_cycle(l, p, f, exp_wr, exp_wr && (idx == 7));
                if (wren) n_wr++;
                if (frame_done) n_done++;
            end
            gap();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{0, 4, -1, 0, 0, 0, 0};  // no vsync since reset: ignored
        vecs[1] = '{1, 4, -1, 8, 1, 1, 0};  // clean frame
        vecs[2] = '{1, 4,  2, 2, 0, 1, 1};  // FIFO full on 3rd window pixel
        vecs[3] = '{1, 4, -1, 8, 1, 2, 0};  // vsync clears overflow
        vecs[4] = '{1, 2, -1, 4, 0, 2, 0};  // short frame
        vecs[5] = '{1, 4, -1, 8, 1, 3, 0};  // recovery after short frame

        reset    = 1'b1;
        vsync    = 1'b0;
        vsync_n  = 1'b1;
        den      = 1'b0;
        full     = 1'b0;
        pixel    = '0;
        last_din = '0;
        cycle();
        cycle();
        check("rst_wren", 32'(wren), 32'd0);
        check("rst_din", din, 32'd0);
        check("rst_wr_load", 32'(wr_load), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        reset = 1'b0;
        cycle();

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].vs_before) vsync_pulse();
            send_frame(vecs[i].nlines, vecs[i].vs_before, vecs[i].full_idx, nwr, nd);
            check("vec_writes", 32'(nwr), 32'(vecs[i].exp_writes));
            check("vec_frame_done", 32'(nd), 32'(vecs[i].exp_done));
            check("vec_frame_count", 32'(frame_count), 32'(vecs[i].exp_count));
            check("vec_overflow", 32'(overflow), 32'(vecs[i].exp_ovf));
            check("vec_frame_count_n", 32'(frame_count_n), 32'(vecs[i].exp_count));
            check("vec_overflow_n", 32'(overflow_n), 32'(vecs[i].exp_ovf));
        end

        // Reset pulse in the middle of window line 1.
        vsync_pulse();
        for (int p = 0; p < 8; p++) px_cycle(0, p, 1'b0, 1'b0, 1'b0);
        gap();
        px_cycle(1, 0, 1'b0, 1'b0, 1'b0);
        px_cycle(1, 1, 1'b0, 1'b1, 1'b0);
        den   = 1'b1;
        pixel = {8'd1, 8'd2, 8'h5A};
        reset = 1'b1;
        cycle();
        reset    = 1'b0;
        last_din = '0;
        check("midrst_wren", 32'(wren), 32'd0);
        check("midrst_din", din, 32'd0);
        check("midrst_frame_count", 32'(frame_count), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        for (int p = 3; p < 8; p++) px_cycle(1, p, 1'b0, 1'b0, 1'b0);
        gap();
        send_frame(2, 1'b0, -1, nwr, nd);
        check("midrst_no_writes", 32'(nwr), 32'd0);
        vsync_pulse();
        send_frame(4, 1'b1, -1, nwr, nd);
        check("midrst_recover_writes", 32'(nwr), 32'd8);
        check("midrst_recover_count", 32'(frame_count), 32'd1);

        // Counter wrap: preload 65535 completed frames, then run two more.
        force u_dut.frame_count = 16'hFFFF;
        cycle();
        release u_dut.frame_count;
        cycle();
        check("wrap_preset", 32'(frame_count), 32'h0000FFFF);
        vsync_pulse();
        send_frame(4, 1'b1, -1, nwr, nd);
        check("wrap_to_0", 32'(frame_count), 32'd0);
        vsync_pulse();
        send_frame(4, 1'b1, -1, nwr, nd);
        check("wrap_to_1", 32'(frame_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
